// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory: assembles little-endian words from a byte
// stream, writes them at consecutive addresses and stalls the CPU until a load completes.
module imem_boot_loader #(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [15:0]     IDLE_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         word_q, word_d;
  logic [15:0]         idle_cnt_q, idle_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                err_q, err_d;
  logic                byte_ready_q, byte_ready_d;
  logic                mem_we_q, mem_we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     word_cnt_inc;

  assign word_cnt_inc = word_cnt_q + 1'b1;

  always_comb begin
    // NOTE: every _d takes its _q value first so no path through this block can infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    idle_cnt_d  = idle_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = (length > DEPTH) ? DEPTH : length;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          idle_cnt_d = 16'd1;
          err_d      = 1'b0;
          cpu_hold_d = 1'b1;
          state_d    = (length == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (byte_valid) begin
          // idle_cnt counts RECV cycles since the last accept, the current cycle included.
          idle_cnt_d = 16'd1;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_wdata_d = {byte_data, word_q};
            mem_addr_d  = word_cnt_q[ADDR_W-1:0];
            state_d     = S_WRITE;
          end else begin
            word_d[8*byte_cnt_q +: 8] = byte_data;
          end
        end else if (idle_cnt_q >= IDLE_LIMIT) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_inc;
        idle_cnt_d = 16'd1;
        state_d    = (word_cnt_inc == len_q) ? S_DONE : S_RECV;
      end
      S_DONE: begin
        cpu_hold_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered copies of the next-state decode.
  assign byte_ready_d = (state_d == S_RECV);
  assign mem_we_d     = (state_d == S_WRITE);
  assign busy_d       = (state_d == S_RECV) || (state_d == S_WRITE);
  assign done_d       = (state_d == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      idle_cnt_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b1;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      idle_cnt_q   <= idle_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      err_q        <= err_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: memory writes go through a scoreboard queue,
// control timing is checked inline by one task per scenario.
module tb_imem_boot_loader;

  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   length;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_mis = 0;
  int  n_we  = 0;

  localparam logic [44:0] RESET_VEC = {1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};

  imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .length     (length),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Write monitor: every mem_we cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      n_we++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_write got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          n_mis++;
          $display("FAIL write got addr=%0d data=%h, required addr=%0d data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [44:0] out_vec();
    return {byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err};
  endfunction

  task automatic do_start(input logic [ADDR_W:0] len);
    start  = 1'b1;
    length = len;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Presents one byte and returns at the negedge after it has been accepted.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_ready) begin
      n_cmp++;
      n_mis++;
      $display("FAIL byte_wait got byte_ready=0 for %0d cycles, required 1", waited);
      byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; length = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_vec() !== RESET_VEC) begin
      n_mis++;
      $display("FAIL reset_values got %h, required %h", out_vec(), RESET_VEC);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({cpu_hold, done, mem_we, byte_ready} !== 4'b1000) begin
        n_mis++;
        $display("FAIL idle_cycle%0d got hold/done/we/ready=%b, required 1000",
                 i, {cpu_hold, done, mem_we, byte_ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] stream [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_q.push_back('{addr: 7'd0, data: 32'h12345678});
    exp_q.push_back('{addr: 7'd1, data: 32'hDEADBEEF});
    do_start(2);
    n_cmp++;
    if ({busy, byte_ready} !== 2'b11) begin
      n_mis++;
      $display("FAIL b2b_start_latency got busy/ready=%b, required 11", {busy, byte_ready});
    end
    for (int i = 0; i < 8; i++) send_byte(stream[i]);
    byte_valid = 1'b0;
    n_cmp++;
    if ({mem_we, done} !== 2'b10) begin
      n_mis++;
      $display("FAIL b2b_last_write_cycle got we/done=%b, required 10", {mem_we, done});
    end
    @(negedge clk);
    n_cmp++;
    if ({done, cpu_hold, busy, mem_we} !== 4'b1100) begin
      n_mis++;
      $display("FAIL b2b_done_cycle got done/hold/busy/we=%b, required 1100",
               {done, cpu_hold, busy, mem_we});
    end
    @(negedge clk);
    n_cmp++;
    if ({done, cpu_hold} !== 2'b00 || exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL b2b_after_done got done/hold=%b pending=%0d, required 00 pending=0",
               {done, cpu_hold}, exp_q.size());
    end
  endtask

  task automatic test_zero_length();
    int we0 = n_we;
    do_start(0);
    n_cmp++;
    if ({done, busy, byte_ready, cpu_hold} !== 4'b1001) begin
      n_mis++;
      $display("FAIL zero_len_done got done/busy/ready/hold=%b, required 1001",
               {done, busy, byte_ready, cpu_hold});
    end
    @(negedge clk);
    n_cmp++;
    if ({done, cpu_hold} !== 2'b00 || n_we != we0) begin
      n_mis++;
      $display("FAIL zero_len_after got done/hold=%b writes=%0d, required 00 writes=0",
               {done, cpu_hold}, n_we - we0);
    end
  endtask

  task automatic test_timeout();
    int we0 = n_we;
    do_start(1);
    send_byte(8'h11);
    send_byte(8'h22);
    byte_valid = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      if (j > 1) @(negedge clk);
      n_cmp++;
      if (err !== (j == 16)) begin
        n_mis++;
        $display("FAIL timeout_err_cycle%0d got err=%b, required %b", j, err, (j == 16));
      end
    end
    n_cmp++;
    if ({busy, byte_ready, cpu_hold, done} !== 4'b0010 || n_we != we0) begin
      n_mis++;
      $display("FAIL timeout_state got busy/ready/hold/done=%b writes=%0d, required 0010 writes=0",
               {busy, byte_ready, cpu_hold, done}, n_we - we0);
    end
    do_start(1);
    n_cmp++;
    if ({err, busy, cpu_hold} !== 3'b011) begin
      n_mis++;
      $display("FAIL timeout_restart got err/busy/hold=%b, required 011", {err, busy, cpu_hold});
    end
  endtask

  // Continues the load left open by test_timeout and resets it part-way through a word.
  task automatic test_reset_midload();
    int we0 = n_we;
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_vec() !== RESET_VEC) begin
      n_mis++;
      $display("FAIL midload_reset got %h, required %h", out_vec(), RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back('{addr: 7'd0, data: 32'hCAFEF00D});
    do_start(1);
    send_word(32'hCAFEF00D);
    byte_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_mis++;
      $display("FAIL midload_fresh_done got done=%b, required 1", done);
    end
    @(negedge clk);
    n_cmp++;
    if (n_we - we0 != 1 || exp_q.size() != 0 || cpu_hold !== 1'b0) begin
      n_mis++;
      $display("FAIL midload_fresh_writes got writes=%0d pending=%0d hold=%b, required 1 0 0",
               n_we - we0, exp_q.size(), cpu_hold);
    end
  endtask

  task automatic test_full_depth();
    int we0 = n_we;
    logic [31:0] w;
    for (int i = 0; i < 128; i++) begin
      w = {8'(i), 8'(i) ^ 8'h5A, ~8'(i), 8'(i + 3)};
      exp_q.push_back('{addr: 7'(i), data: w});
    end
    do_start(200);
    for (int i = 0; i < 128; i++) begin
      w = {8'(i), 8'(i) ^ 8'h5A, ~8'(i), 8'(i + 3)};
      send_word(w);
      if (i == 10) begin
        byte_valid = 1'b0;
        do_start(3);
        n_cmp++;
        if ({busy, err, done} !== 3'b100) begin
          n_mis++;
          $display("FAIL full_mid_start got busy/err/done=%b, required 100", {busy, err, done});
        end
      end
    end
    byte_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b10) begin
      n_mis++;
      $display("FAIL full_done got done/busy=%b, required 10", {done, busy});
    end
    @(negedge clk);
    n_cmp++;
    if (n_we - we0 != 128 || exp_q.size() != 0 || cpu_hold !== 1'b0) begin
      n_mis++;
      $display("FAIL full_count got writes=%0d pending=%0d hold=%b, required 128 0 0",
               n_we - we0, exp_q.size(), cpu_hold);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_zero_length();
    test_timeout();
    test_reset_midload();
    test_full_depth();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
